regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter BYPASS, default 0: 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
REQ-002 SHALL have port Clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ReadRegister1  input  5  read port 1 address.
REQ-005 SHALL have port ReadRegister2  input  5  read port 2 address.
REQ-006 SHALL have port ReadData1  output  32  read port 1 data.
REQ-007 SHALL have port ReadData2  output  32  read port 2 data.
REQ-008 SHALL have port Busy1  output  1  pending-write flag of register at ReadRegister1.
REQ-009 SHALL have port Busy2  output  1  pending-write flag of register at ReadRegister2.
REQ-010 SHALL have port WriteRegister  input  5  write address.
REQ-011 SHALL have port WriteData  input  32  write data.
REQ-012 SHALL have port RegWrite  input  1  write enable, active high.
REQ-013 SHALL have port ReserveRegister  input  5  register to mark pending.
REQ-014 SHALL have port Reserve  input  1  reservation request, active high.
REQ-015 SHALL have port ReserveGrant  output  1  request accepted this cycle.
REQ-016 SHALL have port PendingCount  output  6  number of registers currently busy.

Function
REQ-017 SHALL hold 32 registers of 32 bits plus one busy bit per register.
REQ-018 SHALL update register WriteRegister with WriteData at rising Clk when RegWrite=1 and WriteRegister!=0; no other register changes.
REQ-019 SHALL ignore writes when RegWrite=0, regardless of WriteRegister/WriteData.
REQ-020 SHALL hardwire register 0: reads return 0, writes ignored, busy bit constant 0, never granted.
REQ-021 SHALL drive ReadDataN combinationally from register ReadRegisterN; ports independent, both may address the same register.
REQ-022 With BYPASS=0, a read of the register being written SHALL return the old value until after the rising edge.
REQ-023 With BYPASS=1, when RegWrite=1 and WriteRegister==ReadRegisterN!=0, ReadDataN SHALL equal WriteData in the same cycle, and BusyN SHALL be 0.
REQ-024 SHALL drive BusyN = busy bit of ReadRegisterN, except as in REQ-023.
REQ-025 SHALL drive ReserveGrant combinationally = Reserve and ReserveRegister!=0 and busy[ReserveRegister]=0.
REQ-026 SHALL set busy[ReserveRegister] at rising Clk when ReserveGrant=1; a refused request SHALL change no state and SHALL NOT be queued.
REQ-027 SHALL clear busy[WriteRegister] at rising Clk on any accepted write (REQ-018); a write to a non-busy register is legal and leaves it non-busy.
REQ-028 Simultaneous accepted write and granted reserve to the same register SHALL update data and leave busy=1 (reserve wins).
REQ-029 SHALL keep PendingCount equal to the population count of busy bits: +1 on grant only, -1 on write clearing a busy bit only, unchanged when both or neither; range 0..31, never wraps.

Reset
REQ-030 Reset_n=0 SHALL immediately, independent of Clk, clear all registers to 0, all busy bits to 0, PendingCount to 0.
REQ-031 While Reset_n=0, writes and reservations SHALL be ignored; ReadData1/2=0, Busy1/2=0, ReserveGrant follows REQ-025 with all busy=0.
REQ-032 Reset asserted mid-operation (pending reservations, write in flight) SHALL discard all state; first edge after Reset_n rises SHALL behave as from power-up.

Verification
REQ-033 Write 42 to r2, then 15 to r2, read both ports at 2 -> 42 then 15 on both ports after each edge.
REQ-034 RegWrite=0, WriteData=12 to r2 holding 15 -> r2 still 15; then RegWrite=1 -> 12; r3, r4 remain 0 (no decoder aliasing).
REQ-035 Write 12 to r0; write 47 to r17, read port1=r2, port2=r17 -> ReadData1=0 for r0, ReadData1=r2 value, ReadData2=47.
REQ-036 Reserve r5 -> Grant=1, Busy1=1 at r5, PendingCount=1; reserve r5 again -> Grant=0, count 1; write 7 to r5 -> Busy=0, count 0, r5=7; same-cycle write+reserve r5 -> data updated, busy=1.
REQ-037 BYPASS=1: write 99 to r9 with ReadRegister1=9 -> ReadData1=99 before edge; BYPASS=0 -> old value before edge, 99 after.
REQ-038 Reserve r1..r3, write r4=5, assert Reset_n=0 between edges -> all outputs 0 and PendingCount=0 immediately; after release r4 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with per-register busy (pending-write) scoreboard
module regfile_scoreboard #(
  parameter bit BYPASS = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        Busy1,
  output logic        Busy2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  input  logic [4:0]  ReserveRegister,
  input  logic        Reserve,
  output logic        ReserveGrant,
  output logic [5:0]  PendingCount
);

  // Entry 0 is held at zero: it is never written and never marked busy.
  logic [31:0] regs [32];
  logic [31:0] busy;
  logic [5:0]  pending_count;

  logic write_accept;
  logic write_clears_busy;
  logic fwd1;
  logic fwd2;

  // Qualify write/reserve requests and decide which read ports take the forwarded write.
  always_comb begin
    write_accept      = RegWrite && (WriteRegister != 5'd0);
    write_clears_busy = write_accept && busy[WriteRegister];
    ReserveGrant      = Reserve && (ReserveRegister != 5'd0) && !busy[ReserveRegister];
    // Forwarding is suppressed while in reset so reads stay at zero.
    fwd1 = BYPASS && Reset_n && write_accept && (WriteRegister == ReadRegister1);
    fwd2 = BYPASS && Reset_n && write_accept && (WriteRegister == ReadRegister2);
  end

  // Read ports: register 0 reads zero, forwarded data wins, otherwise stored value.
  always_comb begin
    ReadData1 = 32'd0;
    ReadData2 = 32'd0;
    Busy1     = 1'b0;
    Busy2     = 1'b0;
    if (fwd1) begin
      ReadData1 = WriteData;
    end else if (ReadRegister1 != 5'd0) begin
      ReadData1 = regs[ReadRegister1];
      Busy1     = busy[ReadRegister1];
    end
    if (fwd2) begin
      ReadData2 = WriteData;
    end else if (ReadRegister2 != 5'd0) begin
      ReadData2 = regs[ReadRegister2];
      Busy2     = busy[ReadRegister2];
    end
  end

  // Register array storage; entry 0 keeps its reset value forever.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (write_accept) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Busy bits: an accepted write clears, a grant sets; the set is applied last so a
  // same-cycle reserve of the register being written leaves it busy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (ReserveGrant && (ReserveRegister == i[4:0])) begin
          busy[i] <= 1'b1;
        end else if (write_accept && (WriteRegister == i[4:0])) begin
          busy[i] <= 1'b0;
        end
      end
      busy[0] <= 1'b0;
    end
  end

  // Pending count tracks popcount(busy) incrementally. A grant can never target a
  // register that is already busy, so grant and clear never hit the same busy bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_count <= 6'd0;
    end else if (ReserveGrant && !write_clears_busy) begin
      pending_count <= pending_count + 6'd1;
    end else if (!ReserveGrant && write_clears_busy) begin
      pending_count <= pending_count - 6'd1;
    end
  end

  assign PendingCount = pending_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard, both BYPASS settings
module tb_regfile_scoreboard;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, ReserveRegister;
  logic [31:0] WriteData;
  logic        RegWrite, Reserve;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        b1_0, b2_0, b1_1, b2_1, g_0, g_1;
  logic [5:0]  pc_0, pc_1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  regfile_scoreboard #(.BYPASS(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_0), .ReadData2(rd2_0), .Busy1(b1_0), .Busy2(b2_0),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveRegister(ReserveRegister), .Reserve(Reserve),
    .ReserveGrant(g_0), .PendingCount(pc_0)
  );

  regfile_scoreboard #(.BYPASS(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_1), .ReadData2(rd2_1), .Busy1(b1_1), .Busy2(b2_1),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveRegister(ReserveRegister), .Reserve(Reserve),
    .ReserveGrant(g_1), .PendingCount(pc_1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference state: plain arrays updated by the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always @(posedge Clk or negedge Reset_n) begin
    bit grant;
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      grant = Reserve && ReserveRegister != 0 && !m_busy[ReserveRegister];
      if (RegWrite && WriteRegister != 0) begin
        m_regs[WriteRegister] = WriteData;
        m_busy[WriteRegister] = 1'b0;
      end
      if (grant) m_busy[ReserveRegister] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!Reset_n || a == 0) return 32'd0;
    if (byp && RegWrite && WriteRegister == a) return WriteData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!Reset_n || a == 0) return 1'b0;
    if (byp && RegWrite && WriteRegister == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_grant();
    return Reserve && ReserveRegister != 0 && !m_busy[ReserveRegister];
  endfunction

  function automatic logic [5:0] exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-period: both instances against the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("m_rd1_b0", rd1_0, exp_rd(ReadRegister1, 1'b0));
      chk("m_rd2_b0", rd2_0, exp_rd(ReadRegister2, 1'b0));
      chk("m_rd1_b1", rd1_1, exp_rd(ReadRegister1, 1'b1));
      chk("m_rd2_b1", rd2_1, exp_rd(ReadRegister2, 1'b1));
      chk("m_busy1_b0", 32'(b1_0), 32'(exp_busy(ReadRegister1, 1'b0)));
      chk("m_busy2_b0", 32'(b2_0), 32'(exp_busy(ReadRegister2, 1'b0)));
      chk("m_busy1_b1", 32'(b1_1), 32'(exp_busy(ReadRegister1, 1'b1)));
      chk("m_busy2_b1", 32'(b2_1), 32'(exp_busy(ReadRegister2, 1'b1)));
      chk("m_grant_b0", 32'(g_0), 32'(exp_grant()));
      chk("m_grant_b1", 32'(g_1), 32'(exp_grant()));
      chk("m_count_b0", 32'(pc_0), 32'(exp_count()));
      chk("m_count_b1", 32'(pc_1), 32'(exp_count()));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    Reserve  = 1'b0;
    WriteRegister = 5'd0;
    WriteData = 32'd0;
    ReserveRegister = 5'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1;
    WriteRegister = a;
    WriteData = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    Reserve = 1'b1;
    ReserveRegister = a;
  endtask

  initial begin
    idle();
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    Reset_n = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();
    chk("reset_rd1", rd1_0, 32'd0);
    chk("reset_count", 32'(pc_0), 32'd0);
    #2 Reset_n = 1'b1;
    tick();

    // Write 42 then 15 to r2; both ports read r2.
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd2;
    wr(5'd2, 32'd42);
    tick();
    chk("r2_42_p1", rd1_0, 32'd42);
    chk("r2_42_p2", rd2_0, 32'd42);
    wr(5'd2, 32'd15);
    tick();
    chk("r2_15_p1", rd1_0, 32'd15);
    chk("r2_15_p2", rd2_1, 32'd15);

    // Disabled write is ignored; enabled write lands; neighbours untouched.
    RegWrite = 1'b0;
    WriteData = 32'd12;
    tick();
    chk("r2_nowrite", rd1_0, 32'd15);
    RegWrite = 1'b1;
    tick();
    chk("r2_12", rd1_0, 32'd12);
    idle();
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    #1;
    chk("r3_zero", rd1_0, 32'd0);
    chk("r4_zero", rd2_0, 32'd0);

    // r0 is hardwired; r17 written.
    wr(5'd0, 32'd12);
    tick();
    wr(5'd17, 32'd47);
    tick();
    idle();
    ReadRegister1 = 5'd0;
    #1;
    chk("r0_zero", rd1_0, 32'd0);
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd17;
    #1;
    chk("r2_still12", rd1_0, 32'd12);
    chk("r17_47", rd2_0, 32'd47);

    // Reservation flow on r5.
    ReadRegister1 = 5'd5;
    rsv(5'd5);
    #1;
    chk("grant_r5", 32'(g_0), 32'd1);
    tick();
    chk("busy_r5", 32'(b1_0), 32'd1);
    chk("count_1", 32'(pc_0), 32'd1);
    chk("regrant_r5", 32'(g_0), 32'd0);
    tick();
    chk("count_still1", 32'(pc_0), 32'd1);
    idle();
    wr(5'd5, 32'd7);
    tick();
    idle();
    #1;
    chk("r5_7", rd1_0, 32'd7);
    chk("r5_free", 32'(b1_0), 32'd0);
    chk("count_0", 32'(pc_0), 32'd0);
    rsv(5'd0);
    #1;
    chk("grant_r0", 32'(g_0), 32'd0);
    wr(5'd5, 32'd8);
    rsv(5'd5);
    tick();
    idle();
    #1;
    chk("r5_8", rd1_0, 32'd8);
    chk("r5_busy_again", 32'(b1_0), 32'd1);
    chk("count_1b", 32'(pc_0), 32'd1);

    // Forwarding: BYPASS=1 sees new data and busy=0 before the edge.
    ReadRegister1 = 5'd9;
    wr(5'd9, 32'd99);
    #1;
    chk("byp1_99", rd1_1, 32'd99);
    chk("byp0_old", rd1_0, 32'd0);
    tick();
    idle();
    #1;
    chk("byp0_99", rd1_0, 32'd99);
    rsv(5'd10);
    tick();
    idle();
    ReadRegister2 = 5'd10;
    wr(5'd10, 32'd3);
    #1;
    chk("byp1_busy0", 32'(b2_1), 32'd0);
    chk("byp0_busy1", 32'(b2_0), 32'd1);
    tick();
    idle();

    // Sweep writes with mixed reservations; the model checks every cycle.
    for (int i = 1; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(32 - i);
      wr(5'(i), 32'(i * 32'h01010101 + 3));
      if (i % 3 == 0) rsv(5'((i + 7) % 32));
      tick();
      idle();
    end

    // Mid-cycle reset discards everything.
    for (int i = 1; i < 4; i++) begin
      rsv(5'(i));
      tick();
    end
    idle();
    wr(5'd4, 32'd5);
    tick();
    idle();
    ReadRegister1 = 5'd4;
    ReadRegister2 = 5'd1;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_rd1", rd1_0, 32'd0);
    chk("rst_busy2", 32'(b2_0), 32'd0);
    chk("rst_count", 32'(pc_1), 32'd0);
    wr(5'd4, 32'd77);
    tick();
    idle();
    #2 Reset_n = 1'b1;
    tick();
    chk("post_rst_r4", rd1_0, 32'd0);
    chk("post_rst_count", 32'(pc_0), 32'd0);
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
